// File: rtl/rv32i_pkg.sv
// RV32I decode-stage shared types: opcodes, op classes, immediate formats
// and the decode-to-execute bundle.
package rv32i_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [3:0] {
        CLS_LUI     = 4'd0,
        CLS_AUIPC   = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JALR    = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_LOAD    = 4'd5,
        CLS_STORE   = 4'd6,
        CLS_OP_IMM  = 4'd7,
        CLS_OP      = 4'd8,
        CLS_SYSTEM  = 4'd9,
        CLS_ILLEGAL = 4'd10
    } op_class_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        op_class_t       op_class;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_wen;
        logic [XLEN-1:0] pc;
    } id_ex_t;

endpackage

// File: rtl/decode_operand_stage_if.sv
// Fetch, register-file, writeback and execute-side signals of the decode stage.
// slave = the decode stage, master = its surroundings.
interface decode_operand_stage_if
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            flush;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [4:0]      rf_rd_reg_num0;
    logic [4:0]      rf_rd_reg_num1;
    logic [XLEN-1:0] rf_read_data0;
    logic [XLEN-1:0] rf_read_data1;
    logic            wb_valid;
    logic [4:0]      wb_reg_num;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    op_class_t       out_op_class;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_pc;

    modport slave (
        input  flush, inst_valid, inst, inst_pc,
        input  rf_read_data0, rf_read_data1,
        input  wb_valid, wb_reg_num, wb_data, out_ready,
        output inst_ready, rf_rd_reg_num0, rf_rd_reg_num1,
        output out_valid, out_op_class, out_funct3, out_funct7b5,
        output out_rs1_data, out_rs2_data, out_imm,
        output out_rd, out_rd_wen, out_pc
    );

    modport master (
        output flush, inst_valid, inst, inst_pc,
        output rf_read_data0, rf_read_data1,
        output wb_valid, wb_reg_num, wb_data, out_ready,
        input  inst_ready, rf_rd_reg_num0, rf_rd_reg_num1,
        input  out_valid, out_op_class, out_funct3, out_funct7b5,
        input  out_rs1_data, out_rs2_data, out_imm,
        input  out_rd, out_rd_wen, out_pc
    );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: picks and sign-extends the immediate
// of the given instruction format.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  imm_fmt_t        i_fmt,
    output logic [XLEN-1:0] o_imm
);
    logic [31:0] w_imm;

    always_comb begin
        w_imm = '0;
        unique case (i_fmt)
            IMM_I: w_imm = {{21{i_inst[31]}}, i_inst[30:20]};
            IMM_S: w_imm = {{21{i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
            IMM_B: w_imm = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25],
                            i_inst[11:8], 1'b0};
            IMM_U: w_imm = {i_inst[31:12], 12'h000};
            IMM_J: w_imm = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20],
                            i_inst[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm));
endmodule

// File: rtl/decode_operand_stage.sv
// RV32I decode/operand-fetch stage with busy scoreboard and output register.
// Optional macro BYPASS_EN: forward wb_data to sources retiring this cycle.
module decode_operand_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN     = rv32i_pkg::XLEN,
    parameter int NUM_REGS = rv32i_pkg::NUM_REGS
) (
    input logic                   clk,
    input logic                   rst_n,
    decode_operand_stage_if.slave bus
);
    logic [6:0]          w_opcode;
    logic [4:0]          w_rs1;
    logic [4:0]          w_rs2;
    logic [4:0]          w_rd;
    op_class_t           w_cls;
    imm_fmt_t            w_fmt;
    logic                w_use1;
    logic                w_use2;
    logic                w_use_rd;
    logic                w_rd_wen;
    logic [XLEN-1:0]     w_imm;
    logic                w_busy1;
    logic                w_busy2;
    logic                w_busyd;
    logic                w_hit1;
    logic                w_hit2;
    logic                w_hitd;
    logic                w_hazard;
    logic                w_ready;
    logic                w_issue;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] r_busy;
    logic                r_valid;
    id_ex_t              r_out;
    id_ex_t              w_dec;

    assign w_opcode = bus.inst[6:0];
    assign w_rs1    = bus.inst[19:15];
    assign w_rs2    = bus.inst[24:20];
    assign w_rd     = bus.inst[11:7];

    always_comb begin
        w_cls    = CLS_ILLEGAL;
        w_fmt    = IMM_NONE;
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_use_rd = 1'b0;
        unique case (w_opcode)
            OPC_LUI:    begin w_cls = CLS_LUI;    w_fmt = IMM_U; w_use_rd = 1'b1; end
            OPC_AUIPC:  begin w_cls = CLS_AUIPC;  w_fmt = IMM_U; w_use_rd = 1'b1; end
            OPC_JAL:    begin w_cls = CLS_JAL;    w_fmt = IMM_J; w_use_rd = 1'b1; end
            OPC_JALR:   begin w_cls = CLS_JALR;   w_fmt = IMM_I; w_use1 = 1'b1; w_use_rd = 1'b1; end
            OPC_BRANCH: begin w_cls = CLS_BRANCH; w_fmt = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1; end
            OPC_LOAD:   begin w_cls = CLS_LOAD;   w_fmt = IMM_I; w_use1 = 1'b1; w_use_rd = 1'b1; end
            OPC_STORE:  begin w_cls = CLS_STORE;  w_fmt = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1; end
            OPC_OP_IMM: begin w_cls = CLS_OP_IMM; w_fmt = IMM_I; w_use1 = 1'b1; w_use_rd = 1'b1; end
            OPC_OP:     begin w_cls = CLS_OP; w_use1 = 1'b1; w_use2 = 1'b1; w_use_rd = 1'b1; end
            OPC_SYSTEM: begin w_cls = CLS_SYSTEM; w_fmt = IMM_I; end
            default:    begin w_cls = CLS_ILLEGAL; end
        endcase
    end

    assign w_rd_wen = w_use_rd & (w_rd != 5'd0);

    imm_gen #(.XLEN(XLEN)) u_imm (
        .i_inst (bus.inst),
        .i_fmt  (w_fmt),
        .o_imm  (w_imm)
    );

    assign w_busy1 = r_busy[w_rs1] & (w_rs1 != 5'd0);
    assign w_busy2 = r_busy[w_rs2] & (w_rs2 != 5'd0);
    assign w_busyd = r_busy[w_rd]  & (w_rd  != 5'd0);

`ifdef BYPASS_EN
    assign w_hit1 = bus.wb_valid & (bus.wb_reg_num == w_rs1);
    assign w_hit2 = bus.wb_valid & (bus.wb_reg_num == w_rs2);
    assign w_hitd = bus.wb_valid & (bus.wb_reg_num == w_rd);
`else
    logic [XLEN-1:0] w_unused_wb_data;
    assign w_unused_wb_data = bus.wb_data;
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
    assign w_hitd = 1'b0;
`endif

    assign w_hazard = (w_use1 & w_busy1 & ~w_hit1)
                    | (w_use2 & w_busy2 & ~w_hit2)
                    | (w_rd_wen & w_busyd & ~w_hitd);
    assign w_ready  = rst_n & ~bus.flush & (~r_valid | bus.out_ready) & ~w_hazard;
    assign w_issue  = bus.inst_valid & w_ready;

    always_comb begin
        w_dec          = '0;
        w_dec.op_class = w_cls;
        w_dec.funct3   = bus.inst[14:12];
        w_dec.funct7b5 = bus.inst[30];
        w_dec.rs1_data = (w_hit1 & w_busy1) ? bus.wb_data : bus.rf_read_data0;
        w_dec.rs2_data = (w_hit2 & w_busy2) ? bus.wb_data : bus.rf_read_data1;
        w_dec.imm      = w_imm;
        w_dec.rd       = w_rd;
        w_dec.rd_wen   = w_rd_wen;
        w_dec.pc       = bus.inst_pc;
    end

    // Set after clears so a new writer of the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.wb_valid)
            w_busy_nxt[bus.wb_reg_num] = 1'b0;
        if (bus.flush & r_valid & r_out.rd_wen)
            w_busy_nxt[r_out.rd] = 1'b0;
        if (w_issue & w_rd_wen)
            w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_issue) begin
                r_valid <= 1'b1;
                r_out   <= w_dec;
            end else if (bus.flush | bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.inst_ready     = w_ready;
    assign bus.rf_rd_reg_num0 = w_rs1;
    assign bus.rf_rd_reg_num1 = w_rs2;
    assign bus.out_valid      = r_valid;
    assign bus.out_op_class   = r_out.op_class;
    assign bus.out_funct3     = r_out.funct3;
    assign bus.out_funct7b5   = r_out.funct7b5;
    assign bus.out_rs1_data   = r_out.rs1_data;
    assign bus.out_rs2_data   = r_out.rs2_data;
    assign bus.out_imm        = r_out.imm;
    assign bus.out_rd         = r_out.rd;
    assign bus.out_rd_wen     = r_out.rd_wen;
    assign bus.out_pc         = r_out.pc;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Randomized bench for decode_operand_stage against a behavioural model
// of the scoreboard, handshake and decode rules.
module tb_decode_operand_stage;
    import rv32i_pkg::*;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    decode_operand_stage_if #(.XLEN(32)) bus ();

    decode_operand_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [32];
    always_comb bus.rf_read_data0 = rf[bus.rf_rd_reg_num0];
    always_comb bus.rf_read_data1 = rf[bus.rf_rd_reg_num1];

    // model state
    bit          m_valid;
    int          m_cls;
    logic [2:0]  m_f3;
    bit          m_f7;
    logic [31:0] m_a, m_b, m_imm, m_pc;
    logic [4:0]  m_rd;
    bit          m_wen;
    bit [31:0]   m_busy;
    bit          m_last_issue;
    int          inflight[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output int cls,
                                       output bit u1, output bit u2,
                                       output bit ud, output logic [31:0] imm);
        logic [31:0] sgn;
        logic [31:0] ii, is, ib, iu, ij;
        sgn = $signed(ins) >>> 31;
        ii = (sgn << 11) | 32'(ins[30:20]);
        is = (sgn << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
        ib = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
           | (32'(ins[11:8]) << 1);
        iu = ins & 32'hFFFF_F000;
        ij = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
           | (32'(ins[30:21]) << 1);
        u1 = 0; u2 = 0; ud = 0; imm = 0; cls = CLS_ILLEGAL;
        case (ins[6:0])
            OPC_LUI:    begin cls = CLS_LUI;    ud = 1; imm = iu; end
            OPC_AUIPC:  begin cls = CLS_AUIPC;  ud = 1; imm = iu; end
            OPC_JAL:    begin cls = CLS_JAL;    ud = 1; imm = ij; end
            OPC_JALR:   begin cls = CLS_JALR;   u1 = 1; ud = 1; imm = ii; end
            OPC_BRANCH: begin cls = CLS_BRANCH; u1 = 1; u2 = 1; imm = ib; end
            OPC_LOAD:   begin cls = CLS_LOAD;   u1 = 1; ud = 1; imm = ii; end
            OPC_STORE:  begin cls = CLS_STORE;  u1 = 1; u2 = 1; imm = is; end
            OPC_OP_IMM: begin cls = CLS_OP_IMM; u1 = 1; ud = 1; imm = ii; end
            OPC_OP:     begin cls = CLS_OP; u1 = 1; u2 = 1; ud = 1; end
            OPC_SYSTEM: begin cls = CLS_SYSTEM; imm = ii; end
            default:    cls = CLS_ILLEGAL;
        endcase
    endfunction

    // One clock: compare DUT against model at negedge, advance model.
    task automatic step();
        int          cls;
        bit          u1, u2, ud, wen, hz, rdy, iss, h1, h2, hd, acc;
        logic [31:0] imm, a, b, wd;
        logic [4:0]  rs1, rs2, rd, wr;
        bit          wv, rn;
        @(negedge clk);
        rn = rst_n;
        if (!rn) begin
            m_valid = 0; m_cls = 0; m_f3 = 0; m_f7 = 0; m_a = 0; m_b = 0;
            m_imm = 0; m_pc = 0; m_rd = 0; m_wen = 0; m_busy = 0;
            inflight.delete();
        end
        rs1 = bus.inst[19:15];
        rs2 = bus.inst[24:20];
        rd  = bus.inst[11:7];
        wv  = bus.wb_valid;
        wr  = bus.wb_reg_num;
        wd  = bus.wb_data;
        ref_decode(bus.inst, cls, u1, u2, ud, imm);
        wen = ud && rd != 0;
        h1  = BYP && wv && wr == rs1;
        h2  = BYP && wv && wr == rs2;
        hd  = BYP && wv && wr == rd;
        hz  = (u1 && m_busy[rs1] && !h1) || (u2 && m_busy[rs2] && !h2)
           || (wen && m_busy[rd] && !hd);
        rdy = rn && !bus.flush && (!m_valid || bus.out_ready) && !hz;
        iss = bus.inst_valid && rdy;
        a   = (h1 && m_busy[rs1]) ? wd : rf[rs1];
        b   = (h2 && m_busy[rs2]) ? wd : rf[rs2];
        chk("inst_ready", bus.inst_ready, rdy);
        chk("rf_addr0", bus.rf_rd_reg_num0, rs1);
        chk("rf_addr1", bus.rf_rd_reg_num1, rs2);
        chk("out_valid", bus.out_valid, m_valid);
        chk("op_class", bus.out_op_class, m_cls);
        chk("funct3", bus.out_funct3, m_f3);
        chk("funct7b5", bus.out_funct7b5, m_f7);
        chk("rs1_data", bus.out_rs1_data, m_a);
        chk("rs2_data", bus.out_rs2_data, m_b);
        chk("imm", bus.out_imm, m_imm);
        chk("rd", bus.out_rd, m_rd);
        chk("rd_wen", bus.out_rd_wen, m_wen);
        chk("pc", bus.out_pc, m_pc);
        if (rn) begin
            acc = m_valid && bus.out_ready && !bus.flush;
            if (acc && m_wen) inflight.push_back(m_rd);
            if (wv) begin
                m_busy[wr] = 0;
                for (int i = 0; i < inflight.size(); i++)
                    if (inflight[i] == wr) begin
                        inflight.delete(i);
                        break;
                    end
            end
            if (bus.flush && m_valid && m_wen) m_busy[m_rd] = 0;
            if (iss) begin
                m_valid = 1; m_cls = cls; m_f3 = bus.inst[14:12];
                m_f7 = bus.inst[30]; m_a = a; m_b = b; m_imm = imm;
                m_rd = rd; m_wen = wen; m_pc = bus.inst_pc;
                if (wen) m_busy[rd] = 1;
            end else if (bus.flush || bus.out_ready) begin
                m_valid = 0;
            end
        end
        m_last_issue = iss;
        @(posedge clk);
        #1;
        if (rn && wv && wr != 0) rf[wr] = wd;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                         input bit fl, input bit wv, input logic [4:0] wr,
                         input logic [31:0] wd);
        bus.inst_valid = v;
        bus.inst       = ins;
        bus.inst_pc    = $urandom & 32'hFFFF_FFFC;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        bus.wb_valid   = wv;
        bus.wb_reg_num = wr;
        bus.wb_data    = wd;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0]  opc [12];
        logic [31:0] ins;
        opc = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0B};
        ins        = $urandom;
        ins[6:0]   = opc[$urandom_range(0, 11)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    localparam logic [31:0] ADD6  = 32'h0052_8333;
    localparam logic [31:0] ADDI10 = 32'h0010_0513;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_last_issue = 0;
        rf[0] = 0;
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        rst_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_ready", bus.inst_ready, 0);
        step();
        step();
        rst_n = 1;

        // ADDI x5,x0,7
        drive(1, 32'h0070_0293, 1, 0, 0, 0, 0);
        step();
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_cls", bus.out_op_class, CLS_OP_IMM);
        chk("addi_imm", bus.out_imm, 7);
        chk("addi_rd", bus.out_rd, 5);
        chk("addi_wen", bus.out_rd_wen, 1);

        // ADD x6,x5,x5 stalls on x5 until writeback
        drive(1, ADD6, 1, 0, 0, 0, 0);
        #1;
        chk("raw_stall", bus.inst_ready, 0);
        step();
        drive(1, ADD6, 1, 0, 1, 5, 32'hCAFE_0005);
        #1;
        chk("wb_cycle_ready", bus.inst_ready, BYP);
        step();
        drive(!m_last_issue, ADD6, 1, 0, 0, 0, 0);
        #1;
        chk("post_wb_ready", bus.inst_ready, 1);
        step();
        chk("add_rs1", bus.out_rs1_data, 32'hCAFE_0005);
        chk("add_rs2", bus.out_rs2_data, 32'hCAFE_0005);
        chk("add_rd", bus.out_rd, 6);

        // BEQ offset -4
        drive(1, 32'hFE00_0EE3, 1, 0, 0, 0, 0);
        step();
        chk("beq_cls", bus.out_op_class, CLS_BRANCH);
        chk("beq_imm", bus.out_imm, 32'hFFFF_FFFC);
        chk("beq_wen", bus.out_rd_wen, 0);

        // LUI x9 held for 5 cycles with ADDI x10 waiting
        drive(1, 32'h1234_54B7, 1, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1, ADDI10, 0, 0, 0, 0, 0);
            #1;
            chk("stall_ready", bus.inst_ready, 0);
            step();
            chk("stall_rd", bus.out_rd, 9);
            chk("stall_imm", bus.out_imm, 32'h1234_5000);
        end
        drive(1, ADDI10, 1, 0, 0, 0, 0);
        #1;
        chk("release_ready", bus.inst_ready, 1);
        step();
        chk("release_rd", bus.out_rd, 10);

        // LUI x7 held then flushed; ADD x8,x7,x7 must not stall
        drive(0, 0, 1, 0, 0, 0, 0);
        step();
        drive(1, 32'h0000_13B7, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("flush_ready", bus.inst_ready, 0);
        step();
        chk("flush_valid", bus.out_valid, 0);
        drive(1, 32'h0073_8433, 0, 0, 0, 0, 0);
        #1;
        chk("after_flush_ready", bus.inst_ready, 1);
        step();
        chk("after_flush_rd", bus.out_rd, 8);

        // illegal opcode, then reset while stalled
        drive(1, 32'h0000_057F, 1, 0, 0, 0, 0);
        step();
        chk("ill_cls", bus.out_op_class, CLS_ILLEGAL);
        chk("ill_wen", bus.out_rd_wen, 0);
        drive(1, ADDI10, 0, 0, 0, 0, 0);
        step();
        rst_n = 0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        step();
        rst_n = 1;
        drive(1, ADDI10, 1, 0, 0, 0, 0);
        #1;
        chk("post_rst_ready", bus.inst_ready, 1);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.inst_valid && !m_last_issue)) begin
                bus.inst_valid = $urandom_range(0, 3) != 0;
                bus.inst       = gen_inst();
                bus.inst_pc    = $urandom & 32'hFFFF_FFFC;
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.flush     = $urandom_range(0, 19) == 0;
            bus.wb_valid  = 0;
            bus.wb_data   = $urandom;
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.wb_valid   = 1;
                bus.wb_reg_num =
                    5'(inflight[$urandom_range(0, inflight.size() - 1)]);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
